// File: rtl/exec_pkg.sv
// Shared opcode and condition encodings for the execute stage and decode.
// Also hosts the condition evaluator so decode and execute agree on the rules.
package exec_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    CND_ALWAYS = 3'd0,
    CND_LE     = 3'd1,
    CND_L      = 3'd2,
    CND_E      = 3'd3,
    CND_NE     = 3'd4,
    CND_GE     = 3'd5,
    CND_G      = 3'd6,
    CND_NEVER  = 3'd7
  } cond_e;

  // Signed comparisons use the SF^OF "less than" rule.
  function automatic logic cond_eval(input cond_e c, input logic zf,
                                     input logic sf, input logic of);
    logic lt;
    lt = sf ^ of;
    case (c)
      CND_ALWAYS: return 1'b1;
      CND_LE:     return lt | zf;
      CND_L:      return lt;
      CND_E:      return zf;
      CND_NE:     return !zf;
      CND_GE:     return !lt;
      CND_G:      return !lt & !zf;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exec_cc_stage_if.sv
// Operation/result handshake bundle for exec_cc_stage.
//   in_*  : upstream operation offer (valid/ready)
//   out_* : registered result (valid/ready)
// master = producer of operations / consumer of results; slave = the stage.
interface exec_cc_stage_if #(parameter int unsigned W = 64);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_set_cc;
  logic [2:0]   in_cond;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_ovf;
  logic         out_cnd;

  modport master (
    output in_valid, in_op, in_a, in_b, in_set_cc, in_cond, out_ready,
    input  in_ready, out_valid, out_result, out_ovf, out_cnd
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_set_cc, in_cond, out_ready,
    output in_ready, out_valid, out_result, out_ovf, out_cnd
  );
endinterface

// File: rtl/alu_64bit.sv
// Combinational ALU: ADD/SUB/AND/XOR with signed overflow flag.
//   a_i, b_i  : operands (two's complement)
//   op_i      : operation (exec_pkg::op_e)
//   result_o  : result mod 2^W
//   ovf_o     : signed overflow (ADD/SUB only)
module alu_64bit
  import exec_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  op_e          op_i,
  output logic [W-1:0] result_o,
  output logic         ovf_o
);

  always_comb begin
    result_o = '0;
    ovf_o    = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o = a_i + b_i;
        ovf_o    = (a_i[W-1] == b_i[W-1]) && (result_o[W-1] != a_i[W-1]);
      end
      OP_SUB: begin
        result_o = a_i - b_i;
        ovf_o    = (a_i[W-1] != b_i[W-1]) && (result_o[W-1] != a_i[W-1]);
      end
      OP_AND:  result_o = a_i & b_i;
      default: result_o = a_i ^ b_i;
    endcase
  end

endmodule

// File: rtl/exec_cc_stage.sv
// Execute stage with a single-entry output register, architectural condition
// codes and a saturating overflow counter.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : operation in / result out handshake (slave side)
//   cc_zf/sf/of: condition-code register
//   ovf_count  : saturating count of accepted overflowing operations
module exec_cc_stage
  import exec_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  exec_cc_stage_if.slave   bus,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of,
  output logic [15:0]      ovf_count
);

  logic         accept;
  logic [W-1:0] alu_res;
  logic         alu_ovf;

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_result_q, out_result_d;
  logic         out_ovf_q, out_ovf_d;
  logic         out_cnd_q, out_cnd_d;
  logic         zf_q, zf_d, sf_q, sf_d, of_q, of_d;
  logic [15:0]  cnt_q, cnt_d;

  alu_64bit #(.W(W)) u_alu (
    .a_i      (bus.in_a),
    .b_i      (bus.in_b),
    .op_i     (op_e'(bus.in_op)),
    .result_o (alu_res),
    .ovf_o    (alu_ovf)
  );

  // Ready during reset too; reset priority in the register block drops any
  // accept that coincides with it.
  assign bus.in_ready = !rst_n || !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_ovf_d    = out_ovf_q;
    out_cnd_d    = out_cnd_q;
    zf_d         = zf_q;
    sf_d         = sf_q;
    of_d         = of_q;
    cnt_d        = cnt_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_result_d = alu_res;
      out_ovf_d    = alu_ovf;
      // Condition sees the CC as it stood before this operation's update.
      out_cnd_d    = cond_eval(cond_e'(bus.in_cond), zf_q, sf_q, of_q);
      if (bus.in_set_cc) begin
        zf_d = (alu_res == '0);
        sf_d = alu_res[W-1];
        of_d = alu_ovf;
      end
      if (alu_ovf && (cnt_q != '1)) cnt_d = cnt_q + 16'd1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_ovf_q    <= 1'b0;
      out_cnd_q    <= 1'b0;
      zf_q         <= 1'b1;
      sf_q         <= 1'b0;
      of_q         <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_ovf_q    <= out_ovf_d;
      out_cnd_q    <= out_cnd_d;
      zf_q         <= zf_d;
      sf_q         <= sf_d;
      of_q         <= of_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_ovf    = out_ovf_q;
  assign bus.out_cnd    = out_cnd_q;
  assign cc_zf          = zf_q;
  assign cc_sf          = sf_q;
  assign cc_of          = of_q;
  assign ovf_count      = cnt_q;

endmodule

// File: tb/tb_exec_cc_stage.sv
// Scoreboard bench for exec_cc_stage: a negedge monitor models each accepted
// operation, queues the expected result and checks outputs, CC and counter.
module tb_exec_cc_stage;
  localparam int unsigned W = 64;
  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    logic         cnd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic cc_zf, cc_sf, cc_of;
  logic [15:0] ovf_count;

  exec_cc_stage_if #(.W(W)) bus ();

  exec_cc_stage #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .cc_zf     (cc_zf),
    .cc_sf     (cc_sf),
    .cc_of     (cc_of),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          rand_rdy = 1'b0;
  bit          armed    = 1'b0;
  exp_t        sb[$];

  logic        m_zf, m_sf, m_of;
  logic [15:0] m_cnt;

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      if (n_errors >= 200) finish_run();
    end
  endtask

  // Reference model of one operation against the model CC.
  function automatic exp_t model_op(input logic [1:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic [2:0] c);
    exp_t e;
    logic [W:0] wide;
    logic lt;
    e.ovf = 1'b0;
    case (op)
      2'd0: begin wide = {a[W-1], a} + {b[W-1], b}; e.res = wide[W-1:0]; e.ovf = wide[W] ^ wide[W-1]; end
      2'd1: begin wide = {a[W-1], a} - {b[W-1], b}; e.res = wide[W-1:0]; e.ovf = wide[W] ^ wide[W-1]; end
      2'd2: e.res = a & b;
      default: e.res = a ^ b;
    endcase
    lt = m_sf ^ m_of;
    case (c)
      3'd0: e.cnd = 1'b1;
      3'd1: e.cnd = lt | m_zf;
      3'd2: e.cnd = lt;
      3'd3: e.cnd = m_zf;
      3'd4: e.cnd = !m_zf;
      3'd5: e.cnd = !lt;
      3'd6: e.cnd = !lt && !m_zf;
      default: e.cnd = 1'b0;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      check_eq("in_ready", bus.in_ready, (!rst_n || sb.size() == 0 || bus.out_ready));
      check_eq("out_valid", bus.out_valid, sb.size() != 0);
      if (sb.size() != 0) begin
        check_eq("out_result", bus.out_result, sb[0].res);
        check_eq("out_ovf", bus.out_ovf, sb[0].ovf);
        check_eq("out_cnd", bus.out_cnd, sb[0].cnd);
        if (bus.out_ready && rst_n) void'(sb.pop_front());
      end
      check_eq("cc_zf", cc_zf, m_zf);
      check_eq("cc_sf", cc_sf, m_sf);
      check_eq("cc_of", cc_of, m_of);
      check_eq("ovf_count", ovf_count, m_cnt);
    end
    if (!rst_n) begin
      armed = 1'b1;
      sb.delete();
      m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0; m_cnt = '0;
    end else if (armed && bus.in_valid && bus.in_ready) begin
      e = model_op(bus.in_op, bus.in_a, bus.in_b, bus.in_cond);
      sb.push_back(e);
      if (bus.in_set_cc) begin
        m_zf = (e.res == '0); m_sf = e.res[W-1]; m_of = e.ovf;
      end
      if (e.ovf && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  end

  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sc, input logic [2:0] c);
    bit acc;
    int unsigned n;
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
    bus.in_set_cc = sc; bus.in_cond = c;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check_eq("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    bus.out_ready = 1'b1;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain", sb.size(), 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 64'd1;
      2: return '1;
      3: return MAXP;
      4: return MINN;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #20_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    n_errors++;
    finish_run();
  end

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0;
    bus.in_set_cc = 1'b0; bus.in_cond = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_result", bus.out_result, '0);
    check_eq("rst_out_ovf", bus.out_ovf, 0);
    check_eq("rst_out_cnd", bus.out_cnd, 0);
    check_eq("rst_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    rst_n = 1'b1;

    // Signed overflow on SUB.
    send(2'd1, MAXP, '1, 1'b1, 3'd0);
    drain();
    check_eq("sub_ovf_cc", {cc_zf, cc_sf, cc_of}, 3'b011);
    check_eq("sub_ovf_cnt", ovf_count, 1);

    // Equal SUB sets ZF, next op evaluates "e" as true.
    send(2'd1, 64'd5, 64'd5, 1'b1, 3'd0);
    send(2'd0, 64'd1, 64'd2, 1'b0, 3'd3);
    drain();

    // Random mix with random downstream backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++)
      send(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)));
    rand_rdy = 1'b0;
    drain();

    // Three stalled cycles, then the held offer goes in on the first ready.
    bus.out_ready = 1'b0;
    send(2'd2, 64'hF0F0, 64'hFF00, 1'b1, 3'd4);
    fork
      send(2'd3, 64'h1234, 64'h1234, 1'b1, 3'd5);
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Four back-to-back ADDs.
    for (int i = 0; i < 4; i++)
      send(2'd0, 64'(i * 100), 64'd7, 1'b1, 3'(i + 1));
    drain();

    // Reset while a result is held, with a concurrent offer.
    bus.out_ready = 1'b0;
    send(2'd0, MAXP, 64'd1, 1'b1, 3'd0);
    rst_n = 1'b0;
    bus.in_valid = 1'b1; bus.in_op = 2'd1; bus.in_a = 64'd9; bus.in_b = 64'd3;
    @(posedge clk); #1;
    rst_n = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    check_eq("rst_mid_valid", bus.out_valid, 0);
    check_eq("rst_mid_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    check_eq("rst_mid_cnt", ovf_count, 0);

    // Saturate the overflow counter.
    for (int i = 0; i < 65535; i++)
      send(2'd0, MAXP, 64'd1, 1'b0, 3'd0);
    drain();
    check_eq("cnt_full", ovf_count, 16'hFFFF);
    send(2'd1, MINN, 64'd1, 1'b1, 3'd0);
    send(2'd0, MINN, MINN, 1'b0, 3'd0);
    drain();
    check_eq("cnt_sat", ovf_count, 16'hFFFF);

    finish_run();
  end

endmodule

// File: doc/exec_cc_stage.md
EXEC_CC_STAGE -- requirements
Module: exec_cc_stage

Interface
REQ-001 Parameter: W, 64, operand/result width in bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; one clock; reset is synchronous and active-low.
REQ-004 in_valid  in  1  upstream offers an operation.
REQ-005 in_ready  out  1  stage accepts this cycle.
REQ-006 in_op  in  2  operation: 0 ADD, 1 SUB, 2 AND, 3 XOR.
REQ-007 in_a, in_b  in  W each  signed two's-complement operands.
REQ-008 in_set_cc  in  1  update condition codes with this operation's flags.
REQ-009 in_cond  in  3  condition to evaluate: 0 always, 1 le, 2 l, 3 e, 4 ne, 5 ge, 6 g, 7 never.
REQ-010 out_valid  out  1  registered result available.
REQ-011 out_ready  in  1  downstream consumes this cycle.
REQ-012 out_result  out  W  registered ALU result.
REQ-013 out_ovf  out  1  registered signed overflow of out_result.
REQ-014 out_cnd  out  1  registered condition outcome.
REQ-015 cc_zf, cc_sf, cc_of  out  1 each  architectural condition-code register.
REQ-016 ovf_count  out  16  saturating count of accepted operations with overflow.

Function
REQ-017 Accept = in_valid & in_ready; in_ready SHALL be !out_valid | out_ready (single-entry output register, full throughput).
REQ-018 Latency SHALL be one cycle: accepted operation appears on out_* at the next edge with out_valid=1.
REQ-019 out_valid SHALL clear when out_ready=1 and no accept occurs; out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 Simultaneous drain and accept SHALL load the new operation with out_valid staying 1.
REQ-021 ADD: a+b mod 2^W; ovf = sign(a)==sign(b) and sign(result)!=sign(a).
REQ-022 SUB: a-b mod 2^W; ovf = sign(a)!=sign(b) and sign(result)!=sign(a).
REQ-023 AND, XOR: bitwise; ovf = 0.
REQ-024 On accept with in_set_cc=1: cc_zf = (result==0), cc_sf = result[W-1], cc_of = ovf; otherwise CC SHALL hold.
REQ-025 out_cnd SHALL be evaluated from CC values before this operation's own CC update (SF^OF rule: le=(SF^OF)|ZF, l=SF^OF, e=ZF, ne=!ZF, ge=!(SF^OF), g=!(SF^OF)&!ZF).
REQ-026 Back-to-back accepts SHALL see the CC written by the immediately preceding accepted operation.
REQ-027 ovf_count SHALL increment on every accept with ovf=1, independent of in_set_cc, saturating at 16'hFFFF.
REQ-028 No state (CC, counter, output register) SHALL change on cycles without accept, except out_valid clearing per REQ-019.

Reset
REQ-029 With rst_n=0 at an edge: out_valid=0, out_result=0, out_ovf=0, out_cnd=0, cc_zf=1, cc_sf=0, cc_of=0, ovf_count=0.
REQ-030 in_ready SHALL be 1 during and immediately after reset; reset mid-transfer SHALL discard the held result and any concurrent accept.

Structure
REQ-031 Opcode (ADD/SUB/AND/XOR) and condition encodings SHALL live in shared package exec_pkg, reused by decode.
REQ-032 Combinational arithmetic SHALL be one sub-module alu_64bit (a, b, op -> result, ovf) instantiated once; SUB path matches existing sub_64bit semantics.
REQ-033 Registers, handshake, CC and counter SHALL reside in exec_cc_stage only.

Verification
REQ-034 SUB a=64'h7FFFFFFFFFFFFFFF, b=-1, set_cc=1 -> result 64'h8000000000000000, ovf=1, next CC zf=0 sf=1 of=1, ovf_count=1.
REQ-035 SUB a=5, b=5, set_cc=1, then cond=3 (e) -> first result 0, CC zf=1; second out_cnd=1.
REQ-036 out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_result stable; in_valid held is accepted on first out_ready=1 cycle.
REQ-037 Streaming 4 ADDs with out_ready=1 -> one result per cycle, no bubbles, results in order.
REQ-038 Assert rst_n=0 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, CC = zf1 sf0 of0, ovf_count=0.
REQ-039 ovf_count preset via 65535 overflowing ADDs (1-based cycles) -> count stays 16'hFFFF on further overflow.
